// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use, data-memory wait, MULT/DIV occupancy, branch squash.
// Optional HAZARD_PERF_EN adds saturating load-use and memory-wait cycle counters.
module pipe_hazard_ctrl #(
    parameter int MD_LAT      = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] fd_opcode,
    input  logic [5:0] fd_funct,
    input  logic [4:0] fd_rs,
    input  logic [4:0] fd_rt,
    input  logic [5:0] dx_opcode,
    input  logic [5:0] dx_funct,
    input  logic [4:0] dx_rt,
    input  logic [5:0] xm_opcode,
    input  logic [4:0] xm_rt,
    input  logic       redirect,
    input  logic       dmem_ack,
    output logic       dmem_req,
    output logic       pc_en,
    output logic       fd_en,
    output logic       dx_en,
    output logic       xm_en,
    output logic       mw_en,
    output logic       dx_bubble,
    output logic       xm_bubble,
    output logic       mw_bubble,
    output logic       fd_flush,
    output logic       md_busy,
    output logic       mem_err,
    output logic [2:0] stall_cause
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0] perf_lu_cnt,
    output logic [15:0] perf_mem_cnt
`endif
);

    localparam int MD_W = $clog2(MD_LAT) + 1;
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LAT - 1);
    localparam logic [4:0] TIMEOUT_W = 5'(MEM_TIMEOUT);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_e;

    state_e          state_q, state_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic [MD_W-1:0] md_cnt_q, md_cnt_d;
    logic            mem_err_q, mem_err_d;
    logic [4:0]      wait_inc;

    logic ld_dx, ld_xm, ldst_xm, md_dx, mfhilo_fd;
    logic fd_rtype, fd_jr, fd_br, fd_jump;
    logic lu, mh_dx, mh_fd, mem_stall, busy;

    logic       pc_en_c, fd_en_c, dx_en_c, xm_en_c, mw_en_c;
    logic       dx_bubble_c, xm_bubble_c, mw_bubble_c, dmem_req_c;
    logic [2:0] cause_c;

    assign ld_dx     = (dx_opcode ==? 6'b100???);
    assign ld_xm     = (xm_opcode ==? 6'b100???);
    assign ldst_xm   = xm_opcode[5];
    assign md_dx     = (dx_opcode == 6'd0) && (dx_funct ==? 6'b0110??);
    assign mfhilo_fd = (fd_opcode == 6'd0) && ((fd_funct == 6'b010000) || (fd_funct == 6'b010010));
    assign fd_rtype  = (fd_opcode == 6'd0);
    assign fd_jr     = fd_rtype && (fd_funct == 6'b001000);
    assign fd_br     = (fd_opcode == 6'd4) || (fd_opcode == 6'd5);
    assign fd_jump   = (fd_opcode == 6'd2) || (fd_opcode == 6'd3);
    assign busy      = (md_cnt_q != '0);

    always_comb begin
        lu = 1'b0;
        if (ld_dx && (dx_rt != 5'd0)) begin
            if ((dx_rt == fd_rs) && !fd_jump)
                lu = 1'b1;
            if ((dx_rt == fd_rt) && ((fd_rtype && !fd_jr) || fd_br))
                lu = 1'b1;
        end
        // Branches/JR resolve in decode, so a load one stage further on still hazards them.
        if (ld_xm && (xm_rt != 5'd0) && (fd_br || fd_jr)) begin
            if ((xm_rt == fd_rs) || (fd_br && (xm_rt == fd_rt)))
                lu = 1'b1;
        end
    end

    assign mh_dx     = busy && md_dx;
    assign mh_fd     = busy && mfhilo_fd;
    // An ack in MEM_WAIT releases the stall in the same cycle.
    assign mem_stall = ((state_q == MEM_WAIT) || ((state_q == RUN) && ldst_xm)) && !dmem_ack;

    always_comb begin
        pc_en_c     = 1'b1;
        fd_en_c     = 1'b1;
        dx_en_c     = 1'b1;
        xm_en_c     = 1'b1;
        mw_en_c     = 1'b1;
        dx_bubble_c = 1'b0;
        xm_bubble_c = 1'b0;
        mw_bubble_c = 1'b0;
        cause_c     = 3'd0;
        dmem_req_c  = ((state_q == RUN) && ldst_xm) || (state_q == MEM_WAIT);
        if (state_q == ERR) begin
            pc_en_c    = 1'b0;
            fd_en_c    = 1'b0;
            dx_en_c    = 1'b0;
            xm_en_c    = 1'b0;
            mw_en_c    = 1'b0;
            dmem_req_c = 1'b0;
            cause_c    = 3'd4;
        end else if (mem_stall) begin
            pc_en_c     = 1'b0;
            fd_en_c     = 1'b0;
            dx_en_c     = 1'b0;
            xm_en_c     = 1'b0;
            mw_bubble_c = 1'b1;
            cause_c     = 3'd3;
        end else if (mh_dx) begin
            pc_en_c     = 1'b0;
            fd_en_c     = 1'b0;
            dx_en_c     = 1'b0;
            xm_bubble_c = 1'b1;
            cause_c     = 3'd2;
        end else if (mh_fd || lu) begin
            pc_en_c     = 1'b0;
            fd_en_c     = 1'b0;
            dx_bubble_c = 1'b1;
            cause_c     = mh_fd ? 3'd2 : 3'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        wait_inc   = {1'b0, wait_cnt_q} + 5'd1;
        unique case (state_q)
            RUN: begin
                if (ldst_xm && !dmem_ack) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 4'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_inc >= TIMEOUT_W) begin
                    state_d   = ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_inc[3:0];
                end
            end
            ERR: mem_err_d = 1'b1;
            default: state_d = RUN;
        endcase

        md_cnt_d = md_cnt_q;
        if (md_dx && dx_en_c)
            md_cnt_d = MD_LOAD;
        else if (busy)
            md_cnt_d = md_cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            md_cnt_q   <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            md_cnt_q   <= md_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign pc_en       = pc_en_c & ~rst;
    assign fd_en       = fd_en_c & ~rst;
    assign dx_en       = dx_en_c & ~rst;
    assign xm_en       = xm_en_c & ~rst;
    assign mw_en       = mw_en_c & ~rst;
    assign dx_bubble   = dx_bubble_c & ~rst;
    assign xm_bubble   = xm_bubble_c & ~rst;
    assign mw_bubble   = mw_bubble_c & ~rst;
    assign dmem_req    = dmem_req_c & ~rst;
    assign fd_flush    = redirect & pc_en_c & ~rst;
    assign md_busy     = busy & ~rst;
    assign mem_err     = mem_err_q & ~rst;
    assign stall_cause = rst ? 3'd0 : cause_c;

`ifdef HAZARD_PERF_EN
    logic [15:0] perf_lu_q, perf_lu_d;
    logic [15:0] perf_mem_q, perf_mem_d;

    always_comb begin
        perf_lu_d  = perf_lu_q;
        perf_mem_d = perf_mem_q;
        if ((cause_c == 3'd1) && (perf_lu_q != '1))
            perf_lu_d = perf_lu_q + 16'd1;
        if ((cause_c == 3'd3) && (perf_mem_q != '1))
            perf_mem_d = perf_mem_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu_q  <= '0;
            perf_mem_q <= '0;
        end else begin
            perf_lu_q  <= perf_lu_d;
            perf_mem_q <= perf_mem_d;
        end
    end

    assign perf_lu_cnt  = perf_lu_q;
    assign perf_mem_cnt = perf_mem_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MD_LAT=4, MEM_TIMEOUT=15); perf counters checked when HAZARD_PERF_EN is defined.
module tb_pipe_hazard_ctrl;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_ADD = 6'h20, F_JR = 6'h08, F_MFHI = 6'h10, F_MFLO = 6'h12, F_MULT = 6'h18, F_DIV = 6'h1A;

    logic clk, rst;
    logic [5:0] fd_opcode, fd_funct, dx_opcode, dx_funct, xm_opcode;
    logic [4:0] fd_rs, fd_rt, dx_rt, xm_rt;
    logic redirect, dmem_ack;
    logic dmem_req, pc_en, fd_en, dx_en, xm_en, mw_en;
    logic dx_bubble, xm_bubble, mw_bubble, fd_flush, md_busy, mem_err;
    logic [2:0] stall_cause;
`ifdef HAZARD_PERF_EN
    logic [15:0] perf_lu_cnt, perf_mem_cnt;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [14:0] v;
    } exp_t;
    exp_t        exp_q[$];
    logic [14:0] got_q[$];
    exp_t        e;
    logic [14:0] g;

    pipe_hazard_ctrl #(.MD_LAT(4), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .fd_opcode(fd_opcode), .fd_funct(fd_funct), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .dx_opcode(dx_opcode), .dx_funct(dx_funct), .dx_rt(dx_rt),
        .xm_opcode(xm_opcode), .xm_rt(xm_rt),
        .redirect(redirect), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
        .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
        .dx_bubble(dx_bubble), .xm_bubble(xm_bubble), .mw_bubble(mw_bubble),
        .fd_flush(fd_flush), .md_busy(md_busy), .mem_err(mem_err), .stall_cause(stall_cause)
`ifdef HAZARD_PERF_EN
        , .perf_lu_cnt(perf_lu_cnt), .perf_mem_cnt(perf_mem_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    function automatic logic [14:0] mk(input logic pc, fd, dx, xm, mw, dxb, xmb, mwb, fl, req, mdb, err,
                                       input logic [2:0] cause);
        return {pc, fd, dx, xm, mw, dxb, xmb, mwb, fl, req, mdb, err, cause};
    endfunction

    function automatic logic [14:0] f_run(input logic req, mdb, fl);
        return mk(1, 1, 1, 1, 1, 0, 0, 0, fl, req, mdb, 0, 3'd0);
    endfunction

    function automatic logic [14:0] f_lu(input logic [2:0] cause, input logic req, mdb);
        return mk(0, 0, 1, 1, 1, 1, 0, 0, 0, req, mdb, 0, cause);
    endfunction

    function automatic logic [14:0] f_mem(input logic mdb);
        return mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, mdb, 0, 3'd3);
    endfunction

    function automatic logic [14:0] f_mhdx();
        return mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 3'd2);
    endfunction

    function automatic logic [14:0] f_err();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd4);
    endfunction

    function automatic logic [14:0] obs();
        return {pc_en, fd_en, dx_en, xm_en, mw_en, dx_bubble, xm_bubble, mw_bubble,
                fd_flush, dmem_req, md_busy, mem_err, stall_cause};
    endfunction

    task automatic set_nop();
        fd_opcode = OP_R; fd_funct = 6'd0; fd_rs = 5'd0; fd_rt = 5'd0;
        dx_opcode = OP_R; dx_funct = 6'd0; dx_rt = 5'd0;
        xm_opcode = OP_R; xm_rt = 5'd0;
        redirect = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name, input logic [14:0] v);
        exp_q.push_back('{name, v});
        @(negedge clk);
        got_q.push_back(obs());
    endtask

    task automatic apply_reset();
        next_cycle();
        rst = 1'b1;
        set_nop();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_nop();
        rst = 1'b1; xm_opcode = OP_SW; redirect = 1'b1;
        expect_now("reset_outputs", 15'd0);
        next_cycle();
        rst = 1'b0; set_nop();
        expect_now("reset_state", f_run(0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.name, g, e.v); end
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        next_cycle(); set_nop(); dx_opcode = OP_LW; dx_rt = 5; fd_funct = F_ADD; fd_rs = 5; fd_rt = 1;
        expect_now("lu_rs", f_lu(3'd1, 0, 0));
        next_cycle(); set_nop(); fd_funct = F_ADD; fd_rs = 5; fd_rt = 1;
        expect_now("lu_release", f_run(0, 0, 0));
        next_cycle(); set_nop(); dx_opcode = OP_LW; dx_rt = 5; fd_funct = F_ADD; fd_rs = 1; fd_rt = 5;
        expect_now("lu_rt", f_lu(3'd1, 0, 0));
        next_cycle(); set_nop(); dx_opcode = OP_LW; dx_rt = 0; fd_funct = F_ADD;
        expect_now("lu_r0", f_run(0, 0, 0));
        next_cycle(); set_nop(); dx_opcode = OP_LW; dx_rt = 5; fd_opcode = OP_J; fd_rs = 5; fd_rt = 5;
        expect_now("lu_jump", f_run(0, 0, 0));
        next_cycle(); set_nop(); dx_opcode = OP_LW; dx_rt = 5; fd_opcode = OP_SW; fd_rs = 1; fd_rt = 5;
        expect_now("lu_store_data", f_run(0, 0, 0));
        next_cycle(); set_nop(); dx_opcode = OP_LW; dx_rt = 5; fd_opcode = OP_SW; fd_rs = 5; fd_rt = 1;
        expect_now("lu_store_base", f_lu(3'd1, 0, 0));
        next_cycle(); set_nop(); dx_opcode = OP_LW; dx_rt = 5; fd_opcode = OP_BEQ; fd_rs = 1; fd_rt = 5;
        expect_now("lu_br_rt", f_lu(3'd1, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.name, g, e.v); end
        end
    endtask

    task automatic test_branch();
        apply_reset();
        next_cycle(); set_nop(); fd_opcode = OP_BEQ; fd_rs = 5; xm_opcode = OP_LW; xm_rt = 5; dmem_ack = 1; redirect = 1;
        expect_now("br_xm_stall", f_lu(3'd1, 1, 0));
        next_cycle(); set_nop(); fd_opcode = OP_BEQ; fd_rs = 5; redirect = 1;
        expect_now("br_flush", f_run(0, 0, 1));
        next_cycle(); set_nop(); fd_funct = F_JR; fd_rs = 5; xm_opcode = OP_LW; xm_rt = 5; dmem_ack = 1;
        expect_now("jr_xm", f_lu(3'd1, 1, 0));
        next_cycle(); set_nop(); fd_funct = F_ADD; fd_rs = 5; fd_rt = 1; xm_opcode = OP_LW; xm_rt = 5; dmem_ack = 1;
        expect_now("xm_add_nostall", f_run(1, 0, 0));
        next_cycle(); set_nop(); fd_opcode = OP_BEQ; fd_rs = 1; fd_rt = 5; xm_opcode = OP_LW; xm_rt = 5; dmem_ack = 1;
        expect_now("br_xm_rt", f_lu(3'd1, 1, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.name, g, e.v); end
        end
    endtask

    task automatic test_mem_wait();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            next_cycle(); set_nop(); xm_opcode = OP_SW; redirect = (i == 1);
            expect_now("mem_stall", f_mem(0));
        end
        next_cycle(); set_nop(); xm_opcode = OP_SW; dmem_ack = 1;
        expect_now("mem_ack", f_run(1, 0, 0));
        next_cycle(); set_nop();
        expect_now("mem_after", f_run(0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.name, g, e.v); end
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            next_cycle(); set_nop(); xm_opcode = OP_LW;
            expect_now("to_wait", f_mem(0));
        end
        next_cycle(); set_nop(); xm_opcode = OP_LW;
        expect_now("to_err", f_err());
        next_cycle(); set_nop(); xm_opcode = OP_LW; dmem_ack = 1;
        expect_now("to_err_ack", f_err());
        next_cycle(); rst = 1;
        expect_now("to_rst", 15'd0);
        next_cycle(); rst = 0; set_nop();
        expect_now("to_recover", f_run(0, 0, 0));
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            next_cycle(); set_nop(); xm_opcode = OP_LW;
            expect_now("to_pre_ack", f_mem(0));
        end
        next_cycle(); set_nop(); xm_opcode = OP_LW; dmem_ack = 1;
        expect_now("to_ack_wins", f_run(1, 0, 0));
        next_cycle(); set_nop();
        expect_now("to_ack_run", f_run(0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.name, g, e.v); end
        end
    endtask

    task automatic test_md();
        apply_reset();
        next_cycle(); set_nop(); dx_funct = F_DIV;
        expect_now("md_issue", f_run(0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            next_cycle(); set_nop(); fd_funct = (i == 1) ? F_MFHI : F_MFLO;
            expect_now("md_mfhilo_stall", f_lu(3'd2, 0, 1));
        end
        next_cycle(); set_nop(); fd_funct = F_MFLO;
        expect_now("md_mflo_go", f_run(0, 0, 0));
        next_cycle(); set_nop(); dx_funct = F_MULT;
        expect_now("md_mult1", f_run(0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            next_cycle(); set_nop(); dx_funct = F_MULT;
            expect_now("md_mult2_stall", f_mhdx());
        end
        next_cycle(); set_nop(); dx_funct = F_MULT;
        expect_now("md_mult2_go", f_run(0, 0, 0));
        next_cycle(); set_nop();
        expect_now("md_busy_tail", f_run(0, 1, 0));
        apply_reset();
        next_cycle(); set_nop(); dx_funct = F_DIV;
        expect_now("md_mem_issue", f_run(0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            next_cycle(); set_nop(); xm_opcode = OP_SW;
            expect_now("md_mem_stall", f_mem(1));
        end
        next_cycle(); set_nop(); xm_opcode = OP_SW; dmem_ack = 1; fd_funct = F_MFLO;
        expect_now("md_mem_ack", f_lu(3'd2, 1, 1));
        next_cycle(); set_nop(); fd_funct = F_MFLO;
        expect_now("md_mem_drained", f_run(0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.name, g, e.v); end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            next_cycle(); set_nop(); xm_opcode = OP_SW;
            expect_now("rm_stall", f_mem(0));
        end
        next_cycle(); rst = 1;
        expect_now("rm_async", 15'd0);
        next_cycle(); rst = 0; set_nop();
        expect_now("rm_release", f_run(0, 0, 0));
        next_cycle(); set_nop(); dx_funct = F_DIV;
        expect_now("rm_div", f_run(0, 0, 0));
        next_cycle(); rst = 1;
        expect_now("rm_md_async", 15'd0);
        next_cycle(); rst = 0; set_nop(); fd_funct = F_MFLO;
        expect_now("rm_md_clear", f_run(0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e.v) begin failures++; $display("FAIL %s got=%b exp=%b", e.name, g, e.v); end
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        apply_reset();
        next_cycle(); set_nop(); dx_opcode = OP_LW; dx_rt = 5; fd_funct = F_ADD; fd_rs = 5;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (perf_lu_cnt !== 16'd3) begin failures++; $display("FAIL perf_lu_small got=%h exp=0003", perf_lu_cnt); end
        repeat (70000) @(posedge clk);
        #1;
        checks++;
        if (perf_lu_cnt !== 16'hFFFF) begin failures++; $display("FAIL perf_lu_sat got=%h exp=ffff", perf_lu_cnt); end
        checks++;
        if (perf_mem_cnt !== 16'd0) begin failures++; $display("FAIL perf_mem_idle got=%h exp=0000", perf_mem_cnt); end
        set_nop();
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_md();
        test_reset_mid();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
